// File: rtl/led_water_pkg.sv
// Shared constants and helpers for the running-light LED generator.
// Keeps LED width, reset pattern and counter sizing in one place.
package led_water_pkg;

  localparam int LED_WIDTH = 8;
  localparam logic [LED_WIDTH-1:0] LED_RESET_PATTERN = 8'h01;

  // Prescaler width: clog2 of the step length, but never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [LED_WIDTH-1:0] rotl1(input logic [LED_WIDTH-1:0] v);
    return {v[LED_WIDTH-2:0], v[LED_WIDTH-1]};
  endfunction

endpackage

// File: rtl/led_step_tick.sv
// Step prescaler: counts 0..STEP_CYCLES-1 and pulses tick for one cycle at terminal count.
// Latency: tick on every STEP_CYCLES-th enabled edge; enable low freezes the count in place.
module led_step_tick
  import led_water_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_width(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc   = (cnt == LAST);
  assign tick = enable && tc;

  // A disabled cycle holds cnt so the interval resumes rather than restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_water.sv
// 8-bit water-flow light: one lit LED rotates left once per STEP_CYCLES running edges.
// Latency: led is registered; stop freezes both pattern and step timer with no pending step.
module led_water
  import led_water_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stop,
  output logic [LED_WIDTH-1:0] led
);

  logic tick;

  led_step_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(~stop),
    .tick  (tick)
  );

  // Rotation of a one-hot value stays one-hot, so the reset pattern guarantees the invariant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_RESET_PATTERN;
    end else if (tick) begin
      led <= rotl1(led);
    end
  end

endmodule

// File: tb/tb_led_water.sv
// Scoreboard bench for led_water: STEP_CYCLES=4 instance (a) and STEP_CYCLES=1 instance (b).
// Stimulus pushes expected led values per edge; a negedge monitor pops and compares.
module tb_led_water;

  typedef struct {
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         id;
  } exp_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic       stop_a, stop_b;
  logic [7:0] led_a, led_b;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  int   vec_id;

  led_water #(.STEP_CYCLES(4)) dut_a (
    .clk  (clk),
    .rst_n(rst_a),
    .stop (stop_a),
    .led  (led_a)
  );

  led_water #(.STEP_CYCLES(1)) dut_b (
    .clk  (clk),
    .rst_n(rst_b),
    .stop (stop_b),
    .led  (led_b)
  );

  // 20 ns period, rising edges at 20, 40, ...; falling edges at 10, 30, ...
  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      if (led_a !== e.exp_a) begin
        n_bad = n_bad + 1;
        $display("FAIL vec%0d dut_a led: got %h expected %h", e.id, led_a, e.exp_a);
      end
      n_cmp = n_cmp + 1;
      if (led_b !== e.exp_b) begin
        n_bad = n_bad + 1;
        $display("FAIL vec%0d dut_b led: got %h expected %h", e.id, led_b, e.exp_b);
      end
      n_cmp = n_cmp + 1;
      if (!$onehot(led_a) || !$onehot(led_b)) begin
        n_bad = n_bad + 1;
        $display("FAIL vec%0d onehot: got a=%h b=%h expected single bit set", e.id, led_a, led_b);
      end
    end
  end

  // One running edge: inputs already set by caller; expectation refers to the state after the edge.
  task automatic cyc(input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    @(posedge clk);
    e.exp_a = ea;
    e.exp_b = eb;
    e.id    = vec_id;
    sb_q.push_back(e);
    vec_id = vec_id + 1;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] pos(input int k);
    logic [7:0] one;
    one = 8'h01;
    return one << (k % 8);
  endfunction

  initial begin
    exp_t e0;
    n_cmp  = 0;
    n_bad  = 0;
    vec_id = 0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    stop_a = 1'b0;
    stop_b = 1'b0;

    // Reset state, sampled at 10 ns before any rising edge.
    e0.exp_a = 8'h01;
    e0.exp_b = 8'h01;
    e0.id    = vec_id;
    vec_id   = vec_id + 1;
    sb_q.push_back(e0);
    #10;
    rst_a = 1'b1;

    // First step on edge 4, wrap back to 0x01 on edge 32, then on to cnt=2/led=0x08 at edge 46.
    for (int i = 1; i <= 46; i++) cyc(pos(i / 4), 8'h01);

    // Stop mid-interval (cnt=2): hold 10 edges, then exactly 2 edges to the next step.
    stop_a = 1'b1;
    for (int i = 0; i < 10; i++) cyc(8'h08, 8'h01);
    stop_a = 1'b0;
    cyc(8'h08, 8'h01);
    cyc(8'h10, 8'h01);

    // Stop on the terminal-count edge: no rotation, then rotation on first running edge.
    cyc(8'h10, 8'h01);
    cyc(8'h10, 8'h01);
    cyc(8'h10, 8'h01);
    stop_a = 1'b1;
    cyc(8'h10, 8'h01);
    stop_a = 1'b0;
    cyc(8'h20, 8'h01);

    // Asynchronous reset between edges while led = 0x20.
    cyc(8'h20, 8'h01);
    cyc(8'h20, 8'h01);
    begin
      exp_t e;
      @(posedge clk);
      #5;
      rst_a = 1'b0;
      e.exp_a = 8'h01;
      e.exp_b = 8'h01;
      e.id    = vec_id;
      vec_id  = vec_id + 1;
      sb_q.push_back(e);
      @(negedge clk);
      #1;
    end
    cyc(8'h01, 8'h01);
    rst_a = 1'b1;
    for (int i = 1; i <= 8; i++) cyc(pos(i / 4), 8'h01);

    // STEP_CYCLES = 1 instance; park instance a in reset.
    rst_a = 1'b0;
    rst_b = 1'b1;
    for (int i = 1; i <= 10; i++) cyc(8'h01, pos(i));
    stop_b = 1'b1;
    for (int i = 0; i < 3; i++) cyc(8'h01, 8'h04);
    stop_b = 1'b0;
    cyc(8'h01, 8'h08);

    // stop is ignored while reset is held.
    rst_b  = 1'b0;
    stop_b = 1'b1;
    cyc(8'h01, 8'h01);
    stop_b = 1'b0;
    rst_b  = 1'b1;
    cyc(8'h01, 8'h02);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad = n_bad + 1;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
